// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer: fixed ALU widths, opcode map,
// FSM state encoding and the command/result FIFO payloads.
package alu_cmd_issuer_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned INST_W  = 3;
  localparam int unsigned STATE_W = 2;

  localparam logic [INST_W-1:0] OP_ADD  = 3'b000;
  localparam logic [INST_W-1:0] OP_SUB  = 3'b001;
  localparam logic [INST_W-1:0] OP_MUL  = 3'b010;
  localparam logic [INST_W-1:0] OP_MAC  = 3'b011;
  localparam logic [INST_W-1:0] OP_XNOR = 3'b100;
  localparam logic [INST_W-1:0] OP_RELU = 3'b101;
  localparam logic [INST_W-1:0] OP_MEAN = 3'b110;
  localparam logic [INST_W-1:0] OP_AMAX = 3'b111;
  // Filler driven on idle cycles; a non-MAC op clears the ALU accumulator.
  localparam logic [INST_W-1:0] OP_IDLE = OP_XNOR;

  localparam logic [STATE_W-1:0] S_RUN   = 2'd0;
  localparam logic [STATE_W-1:0] S_CHAIN = 2'd1;
  localparam logic [STATE_W-1:0] S_GAP   = 2'd2;

  typedef struct packed {
    logic              last;
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic              overflow;
    logic [DATA_W-1:0] data;
  } res_t;

  function automatic logic is_mac(input logic [INST_W-1:0] inst);
    return inst == OP_MAC;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_fifo.sv
// Synchronous FIFO with first-word-fall-through read and a running count of
// "marked" entries (used to know whether a chain terminator is queued).
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   push_i, wdata_i     write strobe and data; wmark_i tags the written entry
//   pop_i               consume head; rdata_o/rmark_o show the head entry
//   nempty_o, full_o    registered occupancy flags
//   count_o             entries held; mark_count_o marked entries held
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   wmark_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   rmark_o,
  output logic                   nempty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] mark_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] mark_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, mark_cnt_q, mark_cnt_d;
  logic             nempty_q, full_q;
  logic             do_push, do_pop;

  // Push on a full FIFO is accepted only when the head leaves the same cycle.
  always_comb begin
    do_pop     = pop_i && nempty_q;
    do_push    = push_i && (!full_q || do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    mark_cnt_d = mark_cnt_q + CNT_W'(do_push && wmark_i)
                            - CNT_W'(do_pop && mark_q[rd_ptr_q]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mark_cnt_q <= '0;
      nempty_q   <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mark_cnt_q <= mark_cnt_d;
      nempty_q   <= (count_d != '0);
      full_q     <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q]  <= wdata_i;
      mark_q[wr_ptr_q] <= wmark_i;
    end
  end

  assign rdata_o      = mem_q[rd_ptr_q];
  assign rmark_o      = mark_q[rd_ptr_q];
  assign nempty_o     = nempty_q;
  assign full_o       = full_q;
  assign count_o      = count_q;
  assign mark_count_o = mark_cnt_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Drives the 12-bit ALU from a host command stream and returns its results.
// MAC chains are issued back-to-back only once the whole chain is queued and
// the result path is empty; one forced idle cycle follows every chain.
// Ports:
//   i_clk, i_rst_n                          clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready                 host command handshake
//   i_cmd_inst/i_cmd_a/i_cmd_b/i_cmd_last   command payload
//   o_alu_valid/o_alu_inst/o_alu_a/o_alu_b  registered ALU input port
//   i_alu_valid/i_alu_data/i_alu_overflow   ALU result (1-cycle latency)
//   o_res_valid/i_res_ready                 host result handshake
//   o_res_data/o_res_overflow               result payload
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [INST_W-1:0] i_cmd_inst,
  input  logic [DATA_W-1:0] i_cmd_a,
  input  logic [DATA_W-1:0] i_cmd_b,
  input  logic              i_cmd_last,
  output logic              o_alu_valid,
  output logic [INST_W-1:0] o_alu_inst,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic              i_alu_valid,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_alu_overflow,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned CMD_W = $bits(cmd_t);
  localparam int unsigned RES_W = $bits(res_t);

  cmd_t             cmd_wdata, cmd_head;
  logic [CMD_W-1:0] cmd_rdata;
  logic [CNT_W-1:0] cmd_count, cmd_last_count, cmd_count_nxt;
  logic             cmd_push, cmd_wmark, cmd_rmark, cmd_nempty, cmd_full;

  res_t             res_wdata, res_head;
  logic [RES_W-1:0] res_rdata;
  logic [CNT_W-1:0] res_count, res_mark_count;
  logic             res_pop, res_rmark, res_nempty, res_full;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   chain_cnt_q, chain_cnt_d;
  logic [1:0]         outstanding_q, outstanding_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               alu_valid_q, alu_valid_d;
  logic [INST_W-1:0]  alu_inst_q, alu_inst_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;

  logic [SUM_W-1:0] inflight;
  logic             issue, has_credit, drained, chain_ok, head_mac, head_end;
  logic             unused_sigs;

  // Command FIFO: entries tagged when they terminate a MAC chain.
  always_comb begin
    cmd_wdata.last = i_cmd_last;
    cmd_wdata.inst = i_cmd_inst;
    cmd_wdata.a    = i_cmd_a;
    cmd_wdata.b    = i_cmd_b;
  end

  assign cmd_push  = i_cmd_valid && cmd_ready_q;
  assign cmd_wmark = i_cmd_last && is_mac(i_cmd_inst);
  assign cmd_head  = cmd_t'(cmd_rdata);

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .push_i       (cmd_push),
    .wdata_i      (cmd_wdata),
    .wmark_i      (cmd_wmark),
    .pop_i        (issue),
    .rdata_o      (cmd_rdata),
    .rmark_o      (cmd_rmark),
    .nempty_o     (cmd_nempty),
    .full_o       (cmd_full),
    .count_o      (cmd_count),
    .mark_count_o (cmd_last_count)
  );

  // Result FIFO: space is reserved at issue time, so returns are never dropped.
  always_comb begin
    res_wdata.overflow = i_alu_overflow;
    res_wdata.data     = i_alu_data;
  end

  assign res_pop  = res_nempty && i_res_ready;
  assign res_head = res_t'(res_rdata);

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .push_i       (i_alu_valid),
    .wdata_i      (res_wdata),
    .wmark_i      (1'b0),
    .pop_i        (res_pop),
    .rdata_o      (res_rdata),
    .rmark_o      (res_rmark),
    .nempty_o     (res_nempty),
    .full_o       (res_full),
    .count_o      (res_count),
    .mark_count_o (res_mark_count)
  );

  assign unused_sigs = ^{res_full, res_mark_count, res_rmark, cmd_rmark};

  // Credit: result slots not yet claimed by held results or in-flight issues.
  assign inflight   = SUM_W'(res_count) + SUM_W'(outstanding_q);
  assign has_credit = inflight < SUM_W'(DEPTH);
  assign drained    = (inflight == '0);
  assign chain_ok   = (cmd_last_count != '0) || cmd_full;
  assign head_mac   = is_mac(cmd_head.inst);
  assign head_end   = head_mac && cmd_head.last;

  // Issue FSM and registered ALU-port next values.
  always_comb begin
    state_d     = state_q;
    chain_cnt_d = chain_cnt_q;
    issue       = 1'b0;
    alu_valid_d = 1'b0;
    alu_inst_d  = OP_IDLE;
    alu_a_d     = '0;
    alu_b_d     = '0;

    case (state_q)
      S_RUN: begin
        if (cmd_nempty) begin
          if (!head_mac && has_credit) begin
            issue = 1'b1;
          end else if (head_mac && chain_ok && drained) begin
            issue       = 1'b1;
            chain_cnt_d = CNT_W'(1);
            state_d     = head_end ? S_GAP : S_CHAIN;
          end
        end
      end
      S_CHAIN: begin
        // The whole chain is already queued, so the head is always present.
        if (cmd_nempty) begin
          issue       = 1'b1;
          chain_cnt_d = chain_cnt_q + CNT_W'(1);
          if (head_end || (chain_cnt_q == CNT_W'(DEPTH - 1))) begin
            state_d = S_GAP;
          end
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (issue) begin
      alu_valid_d = 1'b1;
      alu_inst_d  = cmd_head.inst;
      alu_a_d     = cmd_head.a;
      alu_b_d     = cmd_head.b;
    end
  end

  // Ready is registered from the next occupancy so it drops on the filling edge.
  always_comb begin
    cmd_count_nxt = cmd_count + CNT_W'(cmd_push) - CNT_W'(issue);
    cmd_ready_d   = (cmd_count_nxt != CNT_W'(DEPTH));
    outstanding_d = outstanding_q + 2'(issue) - 2'(i_alu_valid);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= S_RUN;
      chain_cnt_q   <= '0;
      outstanding_q <= '0;
      cmd_ready_q   <= 1'b0;
      alu_valid_q   <= 1'b0;
      alu_inst_q    <= OP_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      chain_cnt_q   <= chain_cnt_d;
      outstanding_q <= outstanding_d;
      cmd_ready_q   <= cmd_ready_d;
      alu_valid_q   <= alu_valid_d;
      alu_inst_q    <= alu_inst_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
    end
  end

  assign o_cmd_ready    = cmd_ready_q;
  assign o_alu_valid    = alu_valid_q;
  assign o_alu_inst     = alu_inst_q;
  assign o_alu_a        = alu_a_q;
  assign o_alu_b        = alu_b_q;
  assign o_res_valid    = res_nempty;
  assign o_res_data     = res_head.data;
  assign o_res_overflow = res_head.overflow;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer with a simple 1-cycle ALU model in the loop.
module tb_alu_cmd_issuer;
  import alu_cmd_issuer_pkg::*;

  logic        clk;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_inst;
  logic [11:0] i_cmd_a, i_cmd_b;
  logic        i_cmd_last;
  logic        o_alu_valid;
  logic [2:0]  o_alu_inst;
  logic [11:0] o_alu_a, o_alu_b;
  logic        m_valid, m_ovf;
  logic [11:0] m_data;
  logic        o_res_valid, i_res_ready, o_res_overflow;
  logic [11:0] o_res_data;

  alu_cmd_issuer #(.DEPTH(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_inst     (i_cmd_inst),
    .i_cmd_a        (i_cmd_a),
    .i_cmd_b        (i_cmd_b),
    .i_cmd_last     (i_cmd_last),
    .o_alu_valid    (o_alu_valid),
    .o_alu_inst     (o_alu_inst),
    .o_alu_a        (o_alu_a),
    .o_alu_b        (o_alu_b),
    .i_alu_valid    (m_valid),
    .i_alu_data     (m_data),
    .i_alu_overflow (m_ovf),
    .o_res_valid    (o_res_valid),
    .i_res_ready    (i_res_ready),
    .o_res_data     (o_res_data),
    .o_res_overflow (o_res_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 12-bit signed ADD/SUB; MAC accumulates (a*b)>>>5, cleared by any non-MAC cycle.
  int acc;
  int s_c;
  always_comb begin
    s_c = 0;
    if (o_alu_valid) begin
      case (o_alu_inst)
        OP_ADD:  s_c = $signed(o_alu_a) + $signed(o_alu_b);
        OP_SUB:  s_c = $signed(o_alu_a) - $signed(o_alu_b);
        OP_MAC:  s_c = acc + (($signed(o_alu_a) * $signed(o_alu_b)) >>> 5);
        default: s_c = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!i_rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ovf   <= 1'b0;
      acc     <= 0;
    end else begin
      m_valid <= o_alu_valid;
      m_data  <= s_c[11:0];
      m_ovf   <= o_alu_valid && (s_c > 2047 || s_c < -2048);
      acc     <= (o_alu_valid && o_alu_inst == OP_MAC) ? s_c : 0;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Activity log, sampled 1 time unit after each falling edge.
  logic        mon_en;
  logic        alu_v_log[$];
  logic [2:0]  alu_i_log[$];
  logic [11:0] res_d[$];
  logic        res_o[$];

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      alu_v_log.push_back(o_alu_valid);
      alu_i_log.push_back(o_alu_inst);
      if (o_res_valid && i_res_ready) begin
        res_d.push_back(o_res_data);
        res_o.push_back(o_res_overflow);
      end
    end
  end

  task automatic clear_logs();
    alu_v_log.delete();
    alu_i_log.delete();
    res_d.delete();
    res_o.delete();
  endtask

  // Entered at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [2:0] inst, input logic [11:0] a, input logic [11:0] b,
                      input logic last);
    bit acc_ok = 0;
    i_cmd_valid = 1'b1;
    i_cmd_inst  = inst;
    i_cmd_a     = a;
    i_cmd_b     = b;
    i_cmd_last  = last;
    for (int k = 0; k < 200 && !acc_ok; k++) begin
      if (o_cmd_ready) acc_ok = 1;
      @(posedge clk);
      if (!acc_ok) @(negedge clk);
    end
    if (!acc_ok) check("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_last  = 1'b0;
  endtask

  task automatic wait_results(input string name, input int n, input int bound);
    for (int k = 0; k < bound && res_d.size() < n; k++) @(negedge clk);
    check({name, "_nres"}, res_d.size(), n);
  endtask

  task automatic valid_indices(output int idx[$]);
    idx.delete();
    foreach (alu_v_log[k]) if (alu_v_log[k]) idx.push_back(k);
  endtask

  typedef struct {
    logic [2:0]  inst;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] exp_d;
    logic        exp_o;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx[$];
    int gap_bad;
    vecs[0] = '{OP_ADD, 12'd100,  12'd50,  12'd150,  1'b0};
    vecs[1] = '{OP_ADD, 12'd2047, 12'd1,   12'h800,  1'b1};
    vecs[2] = '{OP_SUB, 12'h800,  12'd1,   12'h7FF,  1'b1};
    vecs[3] = '{OP_ADD, 12'hFFB,  12'd3,   12'hFFE,  1'b0};
    vecs[4] = '{OP_SUB, 12'd10,   12'd20,  12'hFF6,  1'b0};
    vecs[5] = '{OP_ADD, 12'h800,  12'hFFF, 12'h7FF,  1'b1};
    vecs[6] = '{OP_SUB, 12'h7FF,  12'hFFF, 12'h800,  1'b1};

    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_inst = OP_ADD;
    i_cmd_a = '0; i_cmd_b = '0; i_cmd_last = 1'b0; i_res_ready = 1'b1; mon_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_alu_valid", o_alu_valid, 0);
    check("rst_alu_inst",  o_alu_inst,  OP_IDLE);
    check("rst_alu_a",     o_alu_a,     0);
    check("rst_alu_b",     o_alu_b,     0);
    check("rst_res_valid", o_res_valid, 0);
    check("rst_cmd_ready", o_cmd_ready, 0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", o_cmd_ready, 1);

    // Single commands: issue 1 cycle and result 3 cycles after acceptance.
    for (int i = 0; i < NV; i++) begin
      push(vecs[i].inst, vecs[i].a, vecs[i].b, 1'b0);
      check($sformatf("v%0d_alu_idle", i), o_alu_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_alu_valid", i), o_alu_valid, 1);
      check($sformatf("v%0d_alu_inst", i),  o_alu_inst,  vecs[i].inst);
      check($sformatf("v%0d_alu_a", i),     o_alu_a,     vecs[i].a);
      check($sformatf("v%0d_alu_b", i),     o_alu_b,     vecs[i].b);
      @(negedge clk);
      check($sformatf("v%0d_res_early", i), o_res_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_res_valid", i), o_res_valid, 1);
      check($sformatf("v%0d_res_data", i),  o_res_data,  vecs[i].exp_d);
      check($sformatf("v%0d_res_ovf", i),   o_res_overflow, vecs[i].exp_o);
      @(negedge clk);
      check($sformatf("v%0d_res_popped", i), o_res_valid, 0);
    end

    // One 3-long MAC chain.
    clear_logs(); mon_en = 1'b1;
    push(OP_MAC, 12'd64, 12'd32, 1'b0);
    push(OP_MAC, 12'd64, 12'd32, 1'b0);
    push(OP_MAC, 12'd64, 12'd32, 1'b1);
    wait_results("mac3", 3, 100);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    valid_indices(idx);
    check("mac3_issues", idx.size(), 3);
    if (idx.size() == 3) check("mac3_back_to_back", idx[2] - idx[0], 2);
    if (res_d.size() == 3) begin
      check("mac3_r0", res_d[0], 64);
      check("mac3_r1", res_d[1], 128);
      check("mac3_r2", res_d[2], 192);
      check("mac3_ovf", {res_o[0], res_o[1], res_o[2]}, 0);
    end

    // Two 2-long chains: separated by idle filler cycles.
    clear_logs(); mon_en = 1'b1;
    push(OP_MAC, 12'd64, 12'd32, 1'b0);
    push(OP_MAC, 12'd64, 12'd32, 1'b1);
    push(OP_MAC, 12'd64, 12'd32, 1'b0);
    push(OP_MAC, 12'd64, 12'd32, 1'b1);
    wait_results("mac22", 4, 100);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    valid_indices(idx);
    check("mac22_issues", idx.size(), 4);
    if (idx.size() == 4) begin
      check("mac22_chain1_b2b", idx[1] - idx[0], 1);
      check("mac22_chain2_b2b", idx[3] - idx[2], 1);
      check("mac22_gap_present", (idx[2] - idx[1]) > 1, 1);
      gap_bad = 0;
      for (int k = idx[1] + 1; k < idx[2]; k++) if (alu_i_log[k] !== OP_IDLE) gap_bad++;
      check("mac22_gap_inst_idle", gap_bad, 0);
    end
    if (res_d.size() == 4) begin
      check("mac22_r0", res_d[0], 64);
      check("mac22_r1", res_d[1], 128);
      check("mac22_r2", res_d[2], 64);
      check("mac22_r3", res_d[3], 128);
    end

    // Result backpressure: 8 issued then credit stops, 8 more fill the command FIFO.
    i_res_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(OP_ADD, 12'(i * 10), 12'd1, 1'b0);
    repeat (4) @(negedge clk);
    check("bp_cmd_ready_low", o_cmd_ready, 0);
    check("bp_no_issue",      o_alu_valid, 0);
    check("bp_res_held",      o_res_valid, 1);
    check("bp_res_head",      o_res_data,  1);
    clear_logs(); mon_en = 1'b1;
    i_res_ready = 1'b1;
    wait_results("bp", 16, 300);
    mon_en = 1'b0;
    if (res_d.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("bp_r%0d", i), {res_o[i], res_d[i]}, {1'b0, 12'(i * 10 + 1)});
      end
    end
    repeat (2) @(negedge clk);
    check("bp_drained",       o_res_valid, 0);
    check("bp_cmd_ready_hi",  o_cmd_ready, 1);

    // Reset in the middle of a MAC chain drops everything.
    push(OP_MAC, 12'd64, 12'd32, 1'b0);
    push(OP_MAC, 12'd64, 12'd32, 1'b0);
    push(OP_MAC, 12'd64, 12'd32, 1'b1);
    @(negedge clk);
    check("mrst_chain_started", o_alu_valid, 1);
    i_rst_n = 1'b0;
    @(negedge clk);
    check("mrst_alu_valid", o_alu_valid, 0);
    check("mrst_alu_inst",  o_alu_inst,  OP_IDLE);
    check("mrst_alu_ab",    {o_alu_a, o_alu_b}, 0);
    check("mrst_res_valid", o_res_valid, 0);
    check("mrst_cmd_ready", o_cmd_ready, 0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("mrst_cmd_ready_after", o_cmd_ready, 1);
    clear_logs(); mon_en = 1'b1;
    repeat (8) @(negedge clk);
    valid_indices(idx);
    check("mrst_no_issue", idx.size(), 0);
    check("mrst_no_result", res_d.size(), 0);
    push(OP_ADD, 12'd7, 12'd8, 1'b0);
    wait_results("mrst_add", 1, 50);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    if (res_d.size() == 1) check("mrst_add_data", {res_o[0], res_d[0]}, {1'b0, 12'd15});
    valid_indices(idx);
    check("mrst_add_issues", idx.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
